tri_bus_arbiter: RTL
====================

// Module: tri_bus_arbiter
// PURPOSE
//   Round-robin arbiter for one shared tri-state bus line driven by N_REQ sources.
//   Generates the sel/enable pair that steers the tri-state driver bank, plus
//   one-hot grants back to the requesters.
//   Inserts one turnaround cycle between owners so two drivers never overlap on the bus.
// PARAMETERS
//   N_REQ     4  number of requesters / bus drivers (>=2)
//   SEL_W     2  select width, = $clog2(N_REQ)
//   MAX_HOLD  8  max consecutive cycles one owner keeps the bus (>=1)
// PORTS
//   clk     in   1       rising-edge clock
//   rst     in   1       synchronous, active-high reset
//   req     in   N_REQ   request per source; level-sensitive, held while bus needed
//   lock    in   1       hold current grant past MAX_HOLD (only with BUS_ARB_LOCK_EN)
//   sel     out  SEL_W   index of driver steered onto the bus (registered)
//   enable  out  1       tri-state driver enable; 0 = bus released/high-Z (registered)
//   gnt     out  N_REQ   one-hot grant, all-zero when no owner (registered)
//   busy    out  1       state != IDLE
// BEHAVIOUR
// - States: IDLE, GRANT, TURN. All outputs registered.
// - Reset (rst=1 at a clock edge):
//   - state=IDLE; enable=0, gnt=0, sel=0, busy=0.
//   - last-owner pointer = N_REQ-1, so req[0] has first priority.
//   - hold_cnt=0.
// - Winner: first set req bit scanning upward from pointer+1, modulo N_REQ.
// - IDLE:
//   - If |req is sampled at edge k, then from edge k+1: state=GRANT,
//     gnt=onehot(winner), sel=winner, enable=1, hold_cnt=0.
//   - Latency req->grant is 1 cycle. Otherwise stay IDLE.
// - GRANT: hold_cnt increments each cycle. Release when either
//   - req[owner]=0, or
//   - hold_cnt==MAX_HOLD-1 (owner gets exactly MAX_HOLD enabled cycles).
//   On release: state=TURN, enable=0, gnt=0, sel unchanged, pointer=owner.
// - TURN: lasts exactly 1 cycle, with enable=0 and busy=1. At its end:
//   - any req: enter GRANT with a new winner; the gap between owners is exactly 1 cycle.
//   - no req: go to IDLE.
// - Simultaneous events:
//   - req drop coincides with timeout: treated as a single release, one TURN.
//   - Timed-out owner still requesting: loses to any other requester (pointer rule).
//     If it is the sole requester, it is re-granted after TURN.
// - New requests during GRANT do not preempt; they are only considered at release.
// - Reset mid-operation: next cycle enable=0, gnt=0, IDLE, pointer reinitialised.
// - Invariants, every cycle:
//   - gnt is one-hot or zero.
//   - enable == |gnt.
//   - enable implies gnt[sel]==1.
//   - enable is never 1 in consecutive cycles for different sel.
// - Widths:
//   - hold_cnt is $clog2(MAX_HOLD+1) bits and saturates at MAX_HOLD-1.
//   - pointer wraps N_REQ-1 -> 0.
// CONFIGURATION
// - BUS_ARB_LOCK_EN defined:
//   - lock port present.
//   - In GRANT with lock=1 and req[owner]=1, the timeout is suppressed and hold_cnt freezes.
//   - Release happens only when req[owner]=0 or lock=0 with hold_cnt==MAX_HOLD-1.
// - BUS_ARB_LOCK_EN undefined: no lock port; MAX_HOLD is always enforced.
// TESTING
// - Reset: rst=1 for 2 cycles with req=4'b1111 -> enable=0, gnt=0, sel=0 throughout.
//   After rst drops, gnt=4'b0001, sel=0 one cycle later.
// - Single owner: req=4'b0100 for 3 cycles, then 0 -> gnt=4'b0100, sel=2, enable=1
//   for 3 cycles, then 1 TURN cycle with enable=0, then IDLE with busy=0.
// - Fairness: req=4'b1111 held, MAX_HOLD=8 -> owners 0,1,2,3,0 in sequence.
//   Each owner gets 8 enabled cycles followed by a 1-cycle gap; period is 36 cycles.
// - Rotation: pointer=1 with req=4'b1010 -> req3 wins (gnt=4'b1000, sel=3) before req1.
// - Reset mid-GRANT (owner 2) -> next cycle enable=0, gnt=0.
//   A following req=4'b0110 grants req1 first.
// - Lock (BUS_ARB_LOCK_EN): lock=1, req0 held 20 cycles, req1 pending -> req0 enabled
//   20 cycles, then TURN, then req1. Without the macro, req0 releases after 8 cycles.

Source files
------------

// File: rtl/tri_bus_arbiter_if.sv
// Bus-side signal bundle for tri_bus_arbiter; lock exists only when BUS_ARB_LOCK_EN is defined.
// Latency: none (wires only). Backpressure: none; requesters hold req until their grant ends.
// master = arbiter side, slave = requester / driver-bank side.
interface tri_bus_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int SEL_W = 2
);
  logic [N_REQ-1:0] req;
`ifdef BUS_ARB_LOCK_EN
  logic             lock;
`endif
  logic [SEL_W-1:0] sel;
  logic             enable;
  logic [N_REQ-1:0] gnt;
  logic             busy;

`ifdef BUS_ARB_LOCK_EN
  modport master (input req, input lock, output sel, output enable, output gnt, output busy);
  modport slave  (output req, output lock, input sel, input enable, input gnt, input busy);
`else
  modport master (input req, output sel, output enable, output gnt, output busy);
  modport slave  (output req, input sel, input enable, input gnt, input busy);
`endif
endinterface

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner arbiter for a shared tri-state line, one dead cycle between owners (optional BUS_ARB_LOCK_EN).
// Latency: req -> gnt/enable 1 cycle; all outputs registered.
// Backpressure: no preemption; a requester waits until the current owner drops req or times out.
module tri_bus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int SEL_W    = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  tri_bus_arbiter_if.master bus
);

  localparam int              HC_W      = $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] sel_q;
  logic             en_q;
  logic [N_REQ-1:0] gnt_q;
  logic             busy_q;
  logic [HC_W-1:0]  hold_cnt;

  logic             win_vld;
  logic [SEL_W-1:0] win_idx;
  logic [SEL_W-1:0] rr_cand;
  logic             own_req;
  logic             locked;
  logic             release_now;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // First requester strictly after the last owner, wrapping N_REQ-1 -> 0.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    rr_cand = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      rr_cand = SEL_W'((int'(ptr) + i) % N_REQ);
      if (!win_vld && bus.req[rr_cand]) begin
        win_vld = 1'b1;
        win_idx = rr_cand;
      end
    end
  end

  assign own_req = bus.req[sel_q];

`ifdef BUS_ARB_LOCK_EN
  assign locked = bus.lock & own_req;
`else
  assign locked = 1'b0;
`endif

  // A req drop and a timeout on the same edge collapse into one release.
  assign release_now = !own_req || (!locked && (hold_cnt == HOLD_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      en_q     <= 1'b0;
      gnt_q    <= '0;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      ptr      <= SEL_W'(N_REQ - 1);
      hold_cnt <= '0;
    end else begin
      case (state)
        S_IDLE, S_TURN: begin
          if (win_vld) begin
            state    <= S_GRANT;
            gnt_q    <= onehot(win_idx);
            sel_q    <= win_idx;
            en_q     <= 1'b1;
            busy_q   <= 1'b1;
            hold_cnt <= '0;
          end else begin
            state  <= S_IDLE;
            en_q   <= 1'b0;
            gnt_q  <= '0;
            busy_q <= 1'b0;
          end
        end
        S_GRANT: begin
          if (release_now) begin
            state  <= S_TURN;
            en_q   <= 1'b0;
            gnt_q  <= '0;
            busy_q <= 1'b1;
            ptr    <= sel_q;
          end else if (!locked && (hold_cnt != HOLD_LAST)) begin
            hold_cnt <= hold_cnt + HC_W'(1);
          end
        end
        default: begin
          state  <= S_IDLE;
          en_q   <= 1'b0;
          gnt_q  <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel    = sel_q;
  assign bus.enable = en_q;
  assign bus.gnt    = gnt_q;
  assign bus.busy   = busy_q;

endmodule
